// File: rtl/reorder_buffer_pkg.sv
// Shared widths and payload types for the reorder buffer and its retire-side packet.
package reorder_buffer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ROB_SZ = 8;
  localparam int unsigned IDX_W  = $clog2(ROB_SZ);
  localparam int unsigned CNT_W  = $clog2(ROB_SZ + 1);

  typedef struct packed {
    logic             valid;
    logic             complete;
    logic [REG_W-1:0] dest_reg_idx;
    logic [XLEN-1:0]  npc;
    logic [XLEN-1:0]  result;
    logic             take_branch;
    logic             halt;
    logic             illegal;
  } rob_entry_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] rob_index;
    logic [REG_W-1:0] dest_reg_idx;
    logic [XLEN-1:0]  npc;
    logic [XLEN-1:0]  result;
    logic             take_branch;
    logic             halt;
    logic             illegal;
  } co_re_packet_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, complete by index, retire from head.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  input  logic [REG_W-1:0]     dispatch_dest_idx,
  input  logic [XLEN-1:0]      dispatch_NPC,
  input  logic                 dispatch_halt,
  input  logic                 dispatch_illegal,
  output logic [IDX_W-1:0]     dispatch_rob_idx,
  output logic                 rob_full,
  input  logic                 complete_valid,
  input  logic [IDX_W-1:0]     complete_rob_idx,
  input  logic [XLEN-1:0]      complete_result,
  input  logic                 complete_take_br,
  input  logic                 move_head,
  output co_re_packet_t        head_packet,
  output logic [IDX_W-1:0]     rob_head,
  output logic                 rob_empty,
  output logic [CNT_W-1:0]     rob_count
);

  rob_entry_t       entries      [ROB_SZ];
  rob_entry_t       next_entries [ROB_SZ];
  logic [IDX_W-1:0] head_ptr, next_head;
  logic [IDX_W-1:0] tail_ptr, next_tail;
  logic [CNT_W-1:0] count, next_count;
  logic             alloc, retire;
  rob_entry_t       head_e;

  assign head_e           = entries[head_ptr];
  assign rob_full         = (count == CNT_W'(ROB_SZ));
  assign rob_empty        = (count == '0);
  assign rob_count        = count;
  assign rob_head         = head_ptr;
  assign dispatch_rob_idx = tail_ptr;

  // Head view: payload only exposed once the entry is both allocated and complete.
  always_comb begin
    head_packet           = '0;
    head_packet.rob_index = head_ptr;
    if (head_e.valid && head_e.complete) begin
      head_packet.valid        = 1'b1;
      head_packet.dest_reg_idx = head_e.dest_reg_idx;
      head_packet.npc          = head_e.npc;
      head_packet.result       = head_e.result;
      head_packet.take_branch  = head_e.take_branch;
      head_packet.halt         = head_e.halt;
      head_packet.illegal      = head_e.illegal;
    end
  end

  always_comb begin
    next_entries = entries;
    next_head    = head_ptr;
    next_tail    = tail_ptr;
    next_count   = count;
    alloc        = 1'b0;
    retire       = 1'b0;
    if (flush) begin
      for (int i = 0; i < ROB_SZ; i++) begin
        next_entries[i].valid    = 1'b0;
        next_entries[i].complete = 1'b0;
      end
      next_head  = '0;
      next_tail  = '0;
      next_count = '0;
    end else begin
      // Full is judged on the registered count, so a same-cycle retire never frees a slot.
      alloc  = dispatch_valid && !rob_full;
      retire = move_head && head_packet.valid;
      if (complete_valid && entries[complete_rob_idx].valid) begin
        next_entries[complete_rob_idx].complete    = 1'b1;
        next_entries[complete_rob_idx].result      = complete_result;
        next_entries[complete_rob_idx].take_branch = complete_take_br;
      end
      if (retire) begin
        next_entries[head_ptr].valid    = 1'b0;
        next_entries[head_ptr].complete = 1'b0;
        next_head                       = head_ptr + IDX_W'(1);
      end
      if (alloc) begin
        next_entries[tail_ptr].valid        = 1'b1;
        next_entries[tail_ptr].complete     = 1'b0;
        next_entries[tail_ptr].dest_reg_idx = dispatch_dest_idx;
        next_entries[tail_ptr].npc          = dispatch_NPC;
        next_entries[tail_ptr].result       = '0;
        next_entries[tail_ptr].take_branch  = 1'b0;
        next_entries[tail_ptr].halt         = dispatch_halt;
        next_entries[tail_ptr].illegal      = dispatch_illegal;
        next_tail                           = tail_ptr + IDX_W'(1);
      end
      next_count = count + CNT_W'(alloc) - CNT_W'(retire);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      entries  <= '{default: '0};
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      entries  <= next_entries;
      head_ptr <= next_head;
      tail_ptr <= next_tail;
      count    <= next_count;
    end
  end

endmodule
